matrix_generate_nxn: RTL and testbench
======================================

Name: matrix_generate_nxn

Overview:
- Parametrised successor of the 3x3 window generator.
- Turns a raster pixel stream (vsync/href/clken) into a WIN x WIN window of DATA_W-bit pixels for downstream filters (erosion/dilation, Sobel, median).
- Adds runtime row/column tracking, optional zero-masking of unfilled rows, a window-valid flag and line-overflow detection.
- Sits between the binarisation/greyscale stages and any neighbourhood operator.

Parameters:
- DATA_W, 8, pixel width in bits (1 for binary images).
- WIN, 3, window size; odd, 3..7.
- IMG_W_MAX, 1024, maximum pixels per line; line-buffer depth.
- PAD_MODE, 1, 0 = pass stale line-buffer rows; 1 = zero rows not yet filled in current frame.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- per_frame_vsync  in  1  frame sync, high during frame.
- per_frame_href  in  1  line valid.
- per_frame_clken  in  1  pixel strobe.
- per_img_data  in  DATA_W  pixel.
- matrix_frame_vsync  out  1  vsync delayed 2 cycles.
- matrix_frame_href  out  1  href delayed 2 cycles.
- matrix_frame_clken  out  1  clken delayed 2 cycles.
- matrix_data  out  WIN*WIN*DATA_W  window; element (r,c) at bits [(r*WIN+c)*DATA_W +: DATA_W]; r=0 oldest line, r=WIN-1 current line; c=0 oldest column, c=WIN-1 newest.
- matrix_win_valid  out  1  window fully inside image (row_cnt>=WIN-1 and col_cnt>=WIN-1), aligned with matrix_frame_clken.
- line_overflow  out  1  sticky: a line exceeded IMG_W_MAX; cleared on vsync rising edge.

Behaviour:
- Reset (asynchronous): all outputs, window registers, counters, sync pipes = 0. RAM contents undefined; PAD_MODE=1 masks them because row_cnt=0 after reset.
- Accept: per_frame_href & per_frame_clken. Non-accepted cycles change nothing except sync pipes and edge detectors.
- Line buffer: WIN-1 cascaded line delays, each IMG_W_MAX deep.
  - On accept, delay k is read and written at address col_cnt (read-before-write, registered read).
  - Write data is per_img_data for k=0 and the read data of delay k-1 otherwise.
  - Tap k supplies row WIN-2-k. The current pixel is registered one cycle to align with the taps as row WIN-1.
- Latency: pixel accepted at cycle t has its column in c=WIN-1 at t+2; the window shifts left one column per cycle on delayed clken (t+1 stage).
- Stage-1 href low: whole window cleared to 0, so leading columns of each line are zero.
- col_cnt:
  - Increments on accept, saturating at IMG_W_MAX; cleared on href falling edge.
  - Accept with col_cnt==IMG_W_MAX: no RAM write, taps forced 0, line_overflow set.
- row_cnt:
  - Increments on href falling edge, saturating at WIN-1; cleared on vsync rising edge.
  - Both edges in the same cycle: vsync wins, row_cnt=0.
  - line_overflow cleared on vsync rising edge.
- PAD_MODE=1: rows r < WIN-1-row_cnt (row_cnt sampled with the pixel) are forced 0 as they enter the window. PAD_MODE=0: no masking.
- matrix_win_valid: registered, uses row_cnt/col_cnt captured with the pixel (col_cnt after increment); 0 whenever matrix_frame_clken=0.
- Line length may vary per line ≤ IMG_W_MAX; address always restarts at 0 per line.
- Reset mid-frame: state cleared immediately; the next href is treated as line 0 of a frame even without a vsync edge.

Decomposition:
- Shared package image_proc_pkg:
  - clog2 function.
  - win_idx(r,c) bit-offset function.
  - PAD_ZERO/PAD_NONE constants.
- Sub-module line_buffer_ram (DATA_W, DEPTH): single-port read-before-write, registered output, clock enable; instantiated WIN-1 times via generate.

Test Plan (WIN=3, DATA_W=8, IMG_W_MAX=8, PAD_MODE=1 unless stated; pixel = 16*row+col):
- 4x4 frame, contiguous clken -> on line 2 pixel col 2: matrix_data rows {0x00,0x01,0x02},{0x10,0x11,0x12},{0x20,0x21,0x22}; matrix_win_valid=1; sync outputs = inputs delayed exactly 2 cycles.
- Line 1 pixel col 2 -> row 0 = 0 (masked), rows 1,2 = {0x00..0x02},{0x10..0x12}, win_valid=0. Repeat with PAD_MODE=0 on a second frame -> row 0 holds the previous frame's line values.
- clken toggling 1,0,1,0 within a line -> window shifts only on delayed clken; result identical to contiguous case.
- 10-pixel line -> line_overflow=1 from the 9th pixel on, taps 0 for cols 8-9; next vsync rising clears the flag.
- Reset asserted mid line 2 -> all outputs 0 same cycle; after release, next line behaves as row_cnt=0 (rows 0-1 masked).
- vsync rise coincident with href fall -> row_cnt=0; first line of new frame fully masked above.

Source files
------------

// File: rtl/image_proc_pkg.sv
// Shared helpers and constants for the neighbourhood-window image pipeline.
package image_proc_pkg;

    localparam int PAD_NONE = 0;
    localparam int PAD_ZERO = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Bit offset of window element (r,c) inside a flattened WIN x WIN bus.
    function automatic int win_idx(input int r, input int c, input int win, input int data_w);
        return (r * win + c) * data_w;
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Single-port read-before-write line delay with registered read and clock enable.
// The unregistered old word is also exposed so a following delay can be written in the same access.
module line_buffer_ram
    import image_proc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int AW     = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              ce,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] rdata_now
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata_now = mem[addr];

    always_ff @(posedge clk) begin
        if (ce) begin
            rdata     <= mem[addr];
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/matrix_generate_nxn.sv
// Raster stream to WIN x WIN pixel window; newest column lands 2 cycles after accept.
// No backpressure: the window advances on every delayed pixel strobe.
module matrix_generate_nxn
    import image_proc_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int WIN       = 3,
    parameter int IMG_W_MAX = 1024,
    parameter int PAD_MODE  = PAD_ZERO
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       per_frame_vsync,
    input  logic                       per_frame_href,
    input  logic                       per_frame_clken,
    input  logic [DATA_W-1:0]          per_img_data,
    output logic                       matrix_frame_vsync,
    output logic                       matrix_frame_href,
    output logic                       matrix_frame_clken,
    output logic [WIN*WIN*DATA_W-1:0]  matrix_data,
    output logic                       matrix_win_valid,
    output logic                       line_overflow
);

    localparam int NT = WIN - 1;
    localparam int AW = (clog2(IMG_W_MAX) < 1) ? 1 : clog2(IMG_W_MAX);
    localparam int CW = clog2(IMG_W_MAX + 1);
    localparam int RW = clog2(WIN);

    logic              vs_d1, hr_d1, ck_d1;
    logic [CW-1:0]     col_cnt, col_d1;
    logic [RW-1:0]     row_cnt, row_d1;
    logic [DATA_W-1:0] pix_d1;
    logic              ovf_d1;

    logic accept, vs_rise, hr_fall, at_max, ram_ce;

    assign accept  = per_frame_href & per_frame_clken;
    assign vs_rise = per_frame_vsync & ~vs_d1;
    assign hr_fall = hr_d1 & ~per_frame_href;
    assign at_max  = (col_cnt == CW'(IMG_W_MAX));
    assign ram_ce  = accept & ~at_max;

    logic [DATA_W-1:0] tap     [NT];
    logic [DATA_W-1:0] tap_now [NT];
    logic [DATA_W-1:0] wr_dat  [NT];

    for (genvar k = 0; k < NT; k++) begin : g_line
        if (k == 0) begin : g_first
            assign wr_dat[k] = per_img_data;
        end else begin : g_rest
            assign wr_dat[k] = tap_now[k-1];
        end

        line_buffer_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_W_MAX),
            .AW     (AW)
        ) u_ram (
            .clk       (clk),
            .ce        (ram_ce),
            .addr      (col_cnt[AW-1:0]),
            .wdata     (wr_dat[k]),
            .rdata     (tap[k]),
            .rdata_now (tap_now[k])
        );
    end

    // Stage 1: counters, sync pipes and the per-pixel context travelling with the taps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d1              <= 1'b0;
            hr_d1              <= 1'b0;
            ck_d1              <= 1'b0;
            matrix_frame_vsync <= 1'b0;
            matrix_frame_href  <= 1'b0;
            matrix_frame_clken <= 1'b0;
            col_cnt            <= '0;
            row_cnt            <= '0;
            line_overflow      <= 1'b0;
            pix_d1             <= '0;
            row_d1             <= '0;
            col_d1             <= '0;
            ovf_d1             <= 1'b0;
        end else begin
            vs_d1              <= per_frame_vsync;
            hr_d1              <= per_frame_href;
            ck_d1              <= per_frame_clken;
            matrix_frame_vsync <= vs_d1;
            matrix_frame_href  <= hr_d1;
            matrix_frame_clken <= ck_d1;

            if (vs_rise)
                row_cnt <= '0;
            else if (hr_fall && row_cnt != RW'(WIN - 1))
                row_cnt <= row_cnt + RW'(1);

            if (hr_fall)
                col_cnt <= '0;
            else if (accept && !at_max)
                col_cnt <= col_cnt + CW'(1);

            if (vs_rise)
                line_overflow <= 1'b0;
            else if (accept && at_max)
                line_overflow <= 1'b1;

            if (accept) begin
                pix_d1 <= per_img_data;
                row_d1 <= row_cnt;
                col_d1 <= at_max ? col_cnt : col_cnt + CW'(1);
                ovf_d1 <= at_max;
            end
        end
    end

    logic [DATA_W-1:0] new_col [WIN];

    // Tap k feeds row WIN-2-k; rows above the lines seen this frame are blanked when padding.
    always_comb begin
        new_col[WIN-1] = pix_d1;
        for (int k = 0; k < NT; k++) begin
            new_col[WIN-2-k] = tap[k];
            if (ovf_d1 || (PAD_MODE == PAD_ZERO && int'(row_d1) <= k))
                new_col[WIN-2-k] = '0;
        end
    end

    logic [DATA_W-1:0] win_q [WIN][WIN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < WIN; r++)
                for (int c = 0; c < WIN; c++)
                    win_q[r][c] <= '0;
            matrix_win_valid <= 1'b0;
        end else begin
            if (!hr_d1) begin
                for (int r = 0; r < WIN; r++)
                    for (int c = 0; c < WIN; c++)
                        win_q[r][c] <= '0;
            end else if (ck_d1) begin
                for (int r = 0; r < WIN; r++) begin
                    for (int c = 0; c < WIN - 1; c++)
                        win_q[r][c] <= win_q[r][c+1];
                    win_q[r][WIN-1] <= new_col[r];
                end
            end
            matrix_win_valid <= hr_d1 & ck_d1 & (row_d1 == RW'(WIN - 1))
                                & (col_d1 >= CW'(WIN - 1));
        end
    end

    for (genvar r = 0; r < WIN; r++) begin : g_row
        for (genvar c = 0; c < WIN; c++) begin : g_col
            assign matrix_data[win_idx(r, c, WIN, DATA_W) +: DATA_W] = win_q[r][c];
        end
    end

endmodule

// File: tb/tb_matrix_generate_nxn.sv
// Scoreboard bench for matrix_generate_nxn (WIN=3, 8-bit pixels, 8-pixel lines, pixel = 16*row+col).
module tb_matrix_generate_nxn;

    logic       clk = 1'b0;
    logic       rst;
    logic       vsync, href, clken;
    logic [7:0] data;

    logic        o_vs, o_hr, o_ck, o_valid, o_ovf;
    logic [71:0] o_dat;
    logic        p_vs, p_hr, p_ck, p_valid, p_ovf;
    logic [71:0] p_dat;

    typedef struct {
        logic [71:0] dat;
        logic        vld;
        bit          pchk;
        logic [71:0] pdat;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    int         cur_row = 0;
    int         frame_no = 0;
    bit         ovf_m = 1'b0;
    logic [7:0] lv [8][16];
    logic [2:0] hist0, hist1;

    always #5 clk = ~clk;

    matrix_generate_nxn #(.DATA_W(8), .WIN(3), .IMG_W_MAX(8), .PAD_MODE(1)) u_dut (
        .clk(clk), .rst(rst),
        .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
        .per_img_data(data),
        .matrix_frame_vsync(o_vs), .matrix_frame_href(o_hr), .matrix_frame_clken(o_ck),
        .matrix_data(o_dat), .matrix_win_valid(o_valid), .line_overflow(o_ovf)
    );

    matrix_generate_nxn #(.DATA_W(8), .WIN(3), .IMG_W_MAX(8), .PAD_MODE(0)) u_pad0 (
        .clk(clk), .rst(rst),
        .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
        .per_img_data(data),
        .matrix_frame_vsync(p_vs), .matrix_frame_href(p_hr), .matrix_frame_clken(p_ck),
        .matrix_data(p_dat), .matrix_win_valid(p_valid), .line_overflow(p_ovf)
    );

    // Inputs as seen at the last two rising edges; sync outputs must equal the older one.
    always @(posedge clk) begin
        if (rst) begin
            hist0 <= '0;
            hist1 <= '0;
        end else begin
            hist0 <= {vsync, href, clken};
            hist1 <= hist0;
        end
    end

    // Window model: older lines come from this frame's record, blank above row 0, beyond col 7 or left of col 0.
    function automatic logic [71:0] exp_win(int row, int col);
        logic [71:0] w;
        logic [7:0]  v;
        int          ln, cc;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 3; j++) begin
                ln = row - 2 + r;
                cc = col - 2 + j;
                v  = 8'h00;
                if (cc >= 0) begin
                    if (r == 2)
                        v = lv[row][cc];
                    else if (ln >= 0 && cc < 8)
                        v = lv[ln][cc];
                end
                w[(r*3+j)*8 +: 8] = v;
            end
        end
        return w;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                total++;
                if ({o_vs, o_hr, o_ck} !== hist1) begin
                    bad++;
                    $display("FAIL sync_delay got=%b want=%b t=%0t", {o_vs, o_hr, o_ck}, hist1, $time);
                end
                if (o_hr && o_ck) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_window got=%h t=%0t", o_dat, $time);
                    end else begin
                        e = q.pop_front();
                        if (o_dat !== e.dat || o_valid !== e.vld) begin
                            bad++;
                            $display("FAIL window got=%h/%b want=%h/%b t=%0t",
                                     o_dat, o_valid, e.dat, e.vld, $time);
                        end
                        if (e.pchk) begin
                            total++;
                            if (p_dat !== e.pdat) begin
                                bad++;
                                $display("FAIL pad_none_window got=%h want=%h", p_dat, e.pdat);
                            end
                        end
                    end
                end else begin
                    total++;
                    if (o_valid !== 1'b0) begin
                        bad++;
                        $display("FAIL valid_without_clken got=%b want=0 t=%0t", o_valid, $time);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ovf(input string name);
        total++;
        if (o_ovf !== ovf_m) begin
            bad++;
            $display("FAIL %s got=%b want=%b t=%0t", name, o_ovf, ovf_m, $time);
        end
    endtask

    task automatic frame_start();
        vsync = 1'b0;
        tick();
        tick();
        vsync = 1'b1;
        tick();
        cur_row  = 0;
        frame_no++;
        ovf_m    = 1'b0;
        check_ovf("ovf_after_vsync");
    endtask

    task automatic send_line(input int len, input bit gap, input bit rise_at_end, input bit reset_mid);
        exp_t       e;
        logic [7:0] pix;
        for (int c = 0; c < len; c++) begin
            pix = 8'(16 * cur_row + c);
            lv[cur_row][c] = pix;
            e.dat  = exp_win(cur_row, c);
            e.vld  = (cur_row >= 2) && (((c + 1 > 8) ? 8 : c + 1) >= 2);
            e.pchk = (frame_no == 2 && cur_row == 1 && c == 2);
            e.pdat = e.dat;
            e.pdat[23:0] = 24'h323130;
            q.push_back(e);
            href  = 1'b1;
            clken = 1'b1;
            data  = pix;
            tick();
            if (c >= 8) ovf_m = 1'b1;
            check_ovf("ovf_pixel");
            if (gap) begin
                clken = 1'b0;
                data  = 8'hee;
                tick();
            end
        end
        if (reset_mid) begin
            #2;
            rst   = 1'b1;
            href  = 1'b0;
            clken = 1'b0;
            data  = 8'h00;
            q.delete();
            #1;
            total++;
            if ({o_vs, o_hr, o_ck, o_valid, o_ovf, o_dat, p_vs, p_hr, p_ck, p_valid, p_ovf, p_dat} !== '0) begin
                bad++;
                $display("FAIL reset_mid_outputs got=%h/%h want=0", o_dat, {o_vs, o_hr, o_ck, o_valid, o_ovf});
            end
            tick();
            tick();
            rst     = 1'b0;
            cur_row = 0;
            ovf_m   = 1'b0;
            return;
        end
        href  = 1'b0;
        clken = 1'b0;
        data  = 8'h00;
        if (rise_at_end) vsync = 1'b1;
        tick();
        if (rise_at_end) begin
            cur_row = 0;
            frame_no++;
            ovf_m = 1'b0;
        end else begin
            cur_row++;
        end
        tick();
        tick();
    endtask

    initial begin : stimulus
        rst   = 1'b1;
        vsync = 1'b0;
        href  = 1'b0;
        clken = 1'b0;
        data  = 8'h00;
        tick();
        tick();
        total++;
        if ({o_vs, o_hr, o_ck, o_valid, o_ovf, o_dat} !== '0) begin
            bad++;
            $display("FAIL reset_state got=%h/%h want=0", o_dat, {o_vs, o_hr, o_ck, o_valid, o_ovf});
        end
        rst = 1'b0;
        tick();

        frame_start();
        for (int r = 0; r < 4; r++) send_line(4, 1'b0, 1'b0, 1'b0);

        frame_start();
        for (int r = 0; r < 4; r++) send_line(4, 1'b1, 1'b0, 1'b0);

        frame_start();
        send_line(8, 1'b0, 1'b0, 1'b0);
        send_line(8, 1'b0, 1'b0, 1'b0);
        send_line(10, 1'b0, 1'b0, 1'b0);
        check_ovf("ovf_sticky_after_line");
        send_line(4, 1'b0, 1'b0, 1'b0);

        vsync = 1'b0;
        tick();
        tick();
        send_line(4, 1'b0, 1'b1, 1'b0);
        check_ovf("ovf_clear_coincident");
        send_line(4, 1'b0, 1'b0, 1'b0);
        send_line(4, 1'b0, 1'b0, 1'b0);

        send_line(2, 1'b0, 1'b0, 1'b1);
        tick();
        for (int r = 0; r < 3; r++) send_line(4, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 50 && q.size() != 0; i++) tick();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout pending=%0d want=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
